apb_completer_regfile: RTL and testbench

APB completer (slave) with a word-addressed register file, configurable wait states, byte strobes and error response. It is the responder end of the APB bus in `APB_top`: it samples PSEL/PENABLE/PWRITE/PADDR/PWDATA from the requester and returns PRDATA/PREADY/PSLVERR. It replaces the zero-wait, no-error slave model so that requester stall and error handling can be exercised.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_regfile.sv | 40 ++++
 rtl/apb_completer_regfile.sv | 134 +++++++++++++
 tb/tb_apb_completer_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer register file.
package apb_pkg;

  // Setup is a capture edge rather than a held state, so ST_SETUP is never entered.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } apb_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word storage with byte-lane write port and a registered read port that returns 0 when not reading.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  input  logic                    i_rd_en,
  input  logic [IDX_W-1:0]        i_rd_idx,
  output logic [DATA_WIDTH-1:0]   o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (i_wr_strb[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
      // Read samples the array before any same-edge write lands.
      r_rd_data <= i_rd_en ? r_mem[i_rd_idx] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer: setup capture, programmable wait states, address error decode, register file access.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [1:0]              o_dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);

  // Handshake: the requester offers a transfer with PSEL&PENABLE held; it
  // completes on the rising edge where PREADY is also 1 (exactly one cycle).

  apb_state_e            r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_write, r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic                  r_pready, r_pslverr;

  logic             w_setup, w_capture, w_complete, w_addr_err;
  logic             w_sel_write, w_sel_err, w_rd_en, w_wr_en;
  logic [IDX_W-1:0] w_sel_idx;

  assign w_setup    = PSEL && !PENABLE;
  assign w_addr_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) w_capture = 1'b1;
      end
      ST_WAIT: begin
        if (!PSEL) begin
          w_next     = ST_IDLE;
          w_cnt_next = 4'd0;
        end else if (PENABLE) begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_setup) begin
          w_capture = 1'b1;
        end else begin
          w_next     = ST_IDLE;
          w_complete = PSEL && PENABLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_capture) begin
      w_cnt_next = WS;
      w_next     = (WS == 4'd0) ? ST_DONE : ST_WAIT;
    end
  end

  // A zero-wait capture enters DONE on the same edge, so decode uses live inputs.
  assign w_sel_write = w_capture ? PWRITE : r_write;
  assign w_sel_err   = w_capture ? w_addr_err : r_err;
  assign w_sel_idx   = w_capture ? PADDR[IDX_W+1:2] : r_idx;
  assign w_rd_en     = (w_next == ST_DONE) && !w_sel_write && !w_sel_err;
  assign w_wr_en     = w_complete && r_write && !r_err;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= RESP_OKAY;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_capture) begin
        r_write <= PWRITE;
        r_err   <= w_addr_err;
        r_idx   <= PADDR[IDX_W+1:2];
        r_wdata <= PWDATA;
        r_strb  <= PSTRB;
      end
      r_pready  <= (w_next == ST_DONE);
      r_pslverr <= ((w_next == ST_DONE) && w_sel_err) ? RESP_ERR : RESP_OKAY;
    end
  end

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk     (PCLK),
    .i_rst_n   (PRESET),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_wdata),
    .i_wr_strb (r_strb),
    .i_rd_en   (w_rd_en),
    .i_rd_idx  (w_sel_idx),
    .o_rd_data (PRDATA)
  );

  assign PREADY      = r_pready;
  assign PSLVERR     = r_pslverr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: three instances (0, 1 and 3 wait states) checked against a spec-level model.
module tb_apb_completer_regfile;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        psel [3];
  logic        penable [3];
  logic        pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [1:0]  dbg [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_completer_regfile #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .DEPTH       (16),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .PCLK        (clk),
      .PRESET      (rst_n),
      .PSEL        (psel[g]),
      .PENABLE     (penable[g]),
      .PWRITE      (pwrite),
      .PADDR       (paddr),
      .PWDATA      (pwdata),
      .PSTRB       (pstrb),
      .PRDATA      (prdata[g]),
      .PREADY      (pready[g]),
      .PSLVERR     (pslverr[g]),
      .o_dbg_state (dbg[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  // ---------------- model + scoreboard ----------------
  logic [31:0] mem_m [3][16];
  logic [31:0] exp_prdata [3];
  logic        exp_pready [3];
  logic        exp_pslverr [3];
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata [3];
  logic        last_slverr [3];
  int          last_len [3];
  int          cyc [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check($sformatf("pready%0d", d), 32'(pready[d]), 32'(exp_pready[d]));
      check($sformatf("pslverr%0d", d), 32'(pslverr[d]), 32'(exp_pslverr[d]));
      check($sformatf("prdata%0d", d), prdata[d], exp_prdata[d]);
      if (!psel[d]) begin
        cyc[d] = 0;
      end else begin
        cyc[d] = cyc[d] + 1;
        if (pready[d]) begin
          last_len[d]    = cyc[d];
          last_rdata[d]  = prdata[d];
          last_slverr[d] = pslverr[d];
          cyc[d]         = 0;
        end
      end
    end
  end

  task automatic exp_idle(input int d);
    exp_pready[d]  = 1'b0;
    exp_pslverr[d] = 1'b0;
    exp_prdata[d]  = 32'h0;
  endtask

  // ---------------- driver tasks ----------------
  // Drives one full transfer of 2+WS cycles; ends with PSEL low unless another xfer follows at once.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    bit err;
    int idx;
    err = (addr[1:0] != 2'b00) || (addr >= 32'd64);
    idx = int'(addr[5:2]);
    last_len[d]   = 0;
    last_rdata[d] = 32'hxxxx_xxxx;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    psel[d] = 1'b1; penable[d] = 1'b0;
    exp_idle(d);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    repeat (ws_of(d)) begin @(posedge clk); #1; end
    exp_pready[d]  = 1'b1;
    exp_pslverr[d] = err;
    exp_prdata[d]  = (wr || err) ? 32'h0 : mem_m[d][idx];
    @(posedge clk); #1;
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem_m[d][idx][8*b +: 8] = data[8*b +: 8];
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_idle(d);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic read_pin(input int d, input logic [31:0] addr, input logic [31:0] lit, input string name);
    xfer(d, 1'b0, addr, 32'h0, 4'h0);
    exp_q.push_back(lit);
    check(name, last_rdata[d], exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; cyc[d] = 0; last_len[d] = 0;
      last_rdata[d] = '0; last_slverr[d] = 1'b0;
      exp_idle(d);
      for (int w = 0; w < 16; w++) mem_m[d][w] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("reset_state%0d", d), 32'(dbg[d]), 32'(ST_IDLE));
    rst_n = 1'b1;
    idle_cycle();

    // One wait state: basic write then read
    xfer(1, 1'b1, 32'h4, 32'h0000_ABCD, 4'hF);
    check("ws1_wr_len", 32'(last_len[1]), 32'd3);
    check("ws1_wr_slverr", 32'(last_slverr[1]), 32'd0);
    idle_cycle();
    read_pin(1, 32'h4, 32'h0000_ABCD, "ws1_rd_data");
    check("ws1_rd_len", 32'(last_len[1]), 32'd3);
    idle_cycle();

    // Byte strobes
    xfer(1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h3);
    idle_cycle();
    read_pin(1, 32'h8, 32'h0000_FFFF, "strb_lo");
    xfer(1, 1'b1, 32'h8, 32'hAAAA_5555, 4'hC);
    read_pin(1, 32'h8, 32'hAAAA_FFFF, "strb_hi");
    xfer(1, 1'b1, 32'h10, 32'h5555_5555, 4'h0);
    read_pin(1, 32'h10, 32'h0, "strb_none");
    idle_cycle();

    // Error responses
    xfer(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
    check("err_oob_slverr", 32'(last_slverr[1]), 32'd1);
    check("err_oob_prdata", last_rdata[1], 32'h0);
    xfer(1, 1'b1, 32'h6, 32'h1234_5678, 4'hF);
    check("err_mis_slverr", 32'(last_slverr[1]), 32'd1);
    xfer(1, 1'b0, 32'h44, 32'h0, 4'h0);
    check("err_rd_slverr", 32'(last_slverr[1]), 32'd1);
    check("err_rd_prdata", last_rdata[1], 32'h0);
    for (int a = 0; a < 64; a += 4) xfer(1, 1'b0, 32'(a), 32'h0, 4'h0);
    read_pin(1, 32'h4, 32'h0000_ABCD, "err_keep_4");
    idle_cycle();

    // Zero and three wait states, back-to-back write/read
    xfer(0, 1'b1, 32'h4, 32'h1111_2222, 4'hF);
    check("ws0_wr_len", 32'(last_len[0]), 32'd2);
    read_pin(0, 32'h4, 32'h1111_2222, "ws0_rd_data");
    check("ws0_rd_len", 32'(last_len[0]), 32'd2);
    xfer(2, 1'b1, 32'h4, 32'h0000_ABCD, 4'hF);
    check("ws3_wr_len", 32'(last_len[2]), 32'd5);
    read_pin(2, 32'h4, 32'h0000_ABCD, "ws3_rd_data");
    check("ws3_rd_len", 32'(last_len[2]), 32'd5);
    idle_cycle();

    // PENABLE without setup is ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hBAD0_BAD0; pstrb = 4'hF;
    repeat (3) idle_cycle();
    psel[0] = 1'b0; penable[0] = 1'b0;
    idle_cycle();
    read_pin(0, 32'h4, 32'h1111_2222, "penable_idle");
    idle_cycle();

    // Abort during wait
    pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h0000_DEAD; pstrb = 4'hF;
    psel[2] = 1'b1; penable[2] = 1'b0;
    idle_cycle();
    penable[2] = 1'b1;
    idle_cycle();
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (4) idle_cycle();
    read_pin(2, 32'hC, 32'h0, "abort_rd");
    idle_cycle();

    // Asynchronous reset while a read waits
    pwrite = 1'b0; paddr = 32'h4; pstrb = 4'h0;
    psel[2] = 1'b1; penable[2] = 1'b0;
    idle_cycle();
    penable[2] = 1'b1;
    idle_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 32'(dbg[2]), 32'(ST_IDLE));
    check("rst_async_pready", 32'(pready[2]), 32'd0);
    check("rst_async_prdata", prdata[2], 32'h0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++) mem_m[d][w] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    read_pin(2, 32'h4, 32'h0, "rst_clear_ws3");
    read_pin(1, 32'h8, 32'h0, "rst_clear_ws1");
    repeat (2) idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
